// File: rtl/vram_arb_pkg.sv
// ----------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and constants for the framebuffer access arbiter.
//   arb_state_e   : arbiter FSM states (idle / transaction open / turnaround)
//   REQ_GFX       : requester index of the Graphite rasterizer
//   REQ_CPU       : requester index of the CPU bus bridge
//   WDOG_CNT_W    : width of the watchdog cycle counter (limit up to 65535)
//   TIMEOUT_RDATA : read data returned to a requester whose access timed out
// ----------------------------------------------------------------------------
package vram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam logic REQ_GFX = 1'b0;
  localparam logic REQ_CPU = 1'b1;

  localparam int WDOG_CNT_W = 16;

  // Wide enough for any sensible DATA_W; users slice the low bits.
  localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/vram_arb_watchdog.sv
// ----------------------------------------------------------------------------
// vram_arb_watchdog
// Cycle counter that flags an access that has been open for LIMIT cycles.
// Ports:
//   clk        in  clock
//   reset_n_i  in  asynchronous active-low reset
//   clear_i    in  restart the count at zero (held while no access is open)
//   enable_i   in  count one cycle of an open access
//   expired_o  out high during the LIMIT-th enabled cycle since the clear
// ----------------------------------------------------------------------------
module vram_arb_watchdog
  import vram_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // The first enabled cycle sees a count of zero, so the LIMIT-th sees LIMIT-1.
  localparam logic [WDOG_CNT_W-1:0] LAST_COUNT = WDOG_CNT_W'(LIMIT - 1);

  logic [WDOG_CNT_W-1:0] count_q, count_d;

  // Clear has priority so a fresh access always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WDOG_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The arbiter leaves BUSY on this cycle, so it is naturally a single pulse.
  assign expired_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
// Round-robin arbiter sharing the framebuffer access port between the
// Graphite rasterizer (requester 0) and the CPU bus bridge (requester 1).
// One transaction at a time; every output is driven from a register.
//
// Optional feature: define VRAM_ARB_WATCHDOG_EN to abort accesses that get no
// fb_ack_i within TIMEOUT_CYCLES cycles (requester receives all-ones data and
// the sticky err_timeout_o is raised). Without it BUSY waits forever and
// err_timeout_o is tied low.
//
// Ports (N = 0/1):
//   clk, reset_n_i           clock, asynchronous active-low reset
//   req_sel_N_i              request, held with stable fields until ack
//   req_wr_N_i/mask/addr/data  request fields
//   req_ack_N_o              one-cycle completion pulse
//   req_data_N_o             read data, valid with ack, held between acks
//   fb_sel_o/wr/mask/addr/data  framebuffer access port
//   fb_ack_i, fb_data_i      framebuffer completion pulse and read data
//   grant_o                  current or last granted requester
//   busy_o                   arbiter not idle
//   err_timeout_o, err_clr_i sticky watchdog flag and its clear
// ----------------------------------------------------------------------------
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int MASK_W         = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset_n_i,

  input  logic              req_sel_0_i,
  input  logic              req_wr_0_i,
  input  logic [MASK_W-1:0] req_mask_0_i,
  input  logic [ADDR_W-1:0] req_addr_0_i,
  input  logic [DATA_W-1:0] req_data_0_i,
  output logic              req_ack_0_o,
  output logic [DATA_W-1:0] req_data_0_o,

  input  logic              req_sel_1_i,
  input  logic              req_wr_1_i,
  input  logic [MASK_W-1:0] req_mask_1_i,
  input  logic [ADDR_W-1:0] req_addr_1_i,
  input  logic [DATA_W-1:0] req_data_1_i,
  output logic              req_ack_1_o,
  output logic [DATA_W-1:0] req_data_1_o,

  output logic              fb_sel_o,
  output logic              fb_wr_o,
  output logic [MASK_W-1:0] fb_mask_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic [DATA_W-1:0] fb_data_o,
  input  logic              fb_ack_i,
  input  logic [DATA_W-1:0] fb_data_i,

  output logic              grant_o,
  output logic              busy_o,
  output logic              err_timeout_o,
  input  logic              err_clr_i
);

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_RDATA[DATA_W-1:0];

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              fb_sel_q, fb_sel_d;
  logic              fb_wr_q, fb_wr_d;
  logic [MASK_W-1:0] fb_mask_q, fb_mask_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0] fb_data_q, fb_data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              any_req;
  logic              winner;
  logic              fb_done;
  logic              wdog_expired;
  logic              wdog_timeout;
  logic [DATA_W-1:0] done_rdata;

  assign any_req = req_sel_0_i || req_sel_1_i;

  // On a tie the requester that did not win last time goes next; grant_q
  // resets to the CPU so the rasterizer wins the first tie.
  assign winner = (req_sel_0_i && req_sel_1_i) ? ~grant_q
                : (req_sel_1_i ? REQ_CPU : REQ_GFX);

  // A real ack and a timeout in the same cycle resolve in favour of the ack.
  assign fb_done      = (state_q == ARB_BUSY) && fb_ack_i;
  assign wdog_timeout = (state_q == ARB_BUSY) && wdog_expired && !fb_ack_i;
  assign done_rdata   = fb_done ? fb_data_i : TIMEOUT_DATA;

  // State register.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RELEASE is a one-cycle turnaround during which no
  // request is sampled, giving the served requester time to drop sel.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:    if (any_req) state_d = ARB_BUSY;
      ARB_BUSY:    if (fb_ack_i || wdog_expired) state_d = ARB_RELEASE;
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Output next values: latch the winner's request on grant, close the
  // access and route the response back on completion or timeout.
  always_comb begin
    grant_d   = grant_q;
    fb_sel_d  = fb_sel_q;
    fb_wr_d   = fb_wr_q;
    fb_mask_d = fb_mask_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    if ((state_q == ARB_IDLE) && any_req) begin
      grant_d  = winner;
      fb_sel_d = 1'b1;
      if (winner == REQ_CPU) begin
        fb_wr_d   = req_wr_1_i;
        fb_mask_d = req_mask_1_i;
        fb_addr_d = req_addr_1_i;
        fb_data_d = req_data_1_i;
      end else begin
        fb_wr_d   = req_wr_0_i;
        fb_mask_d = req_mask_0_i;
        fb_addr_d = req_addr_0_i;
        fb_data_d = req_data_0_i;
      end
    end

    if (fb_done || wdog_timeout) begin
      fb_sel_d = 1'b0;
      if (grant_q == REQ_CPU) begin
        ack1_d   = 1'b1;
        rdata1_d = done_rdata;
      end else begin
        ack0_d   = 1'b1;
        rdata0_d = done_rdata;
      end
    end
  end

  // Output registers; fb_sel_o drops as soon as reset asserts.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_q   <= REQ_CPU;
      fb_sel_q  <= 1'b0;
      fb_wr_q   <= 1'b0;
      fb_mask_q <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      grant_q   <= grant_d;
      fb_sel_q  <= fb_sel_d;
      fb_wr_q   <= fb_wr_d;
      fb_mask_q <= fb_mask_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

`ifdef VRAM_ARB_WATCHDOG_EN
  logic err_q, err_d;

  vram_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n_i(reset_n_i),
    .clear_i  (state_q == ARB_IDLE),
    .enable_i (state_q == ARB_BUSY),
    .expired_o(wdog_expired)
  );

  // A timeout in the same cycle as a clear still leaves the flag set.
  always_comb begin
    err_d = err_q;
    if (wdog_timeout) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_timeout_o = err_q;
`else
  logic [16:0] unused_cfg;

  assign wdog_expired  = 1'b0;
  assign err_timeout_o = 1'b0;
  assign unused_cfg    = {err_clr_i, 16'(TIMEOUT_CYCLES)};
`endif

  assign busy_o       = (state_q != ARB_IDLE);
  assign grant_o      = grant_q;
  assign fb_sel_o     = fb_sel_q;
  assign fb_wr_o      = fb_wr_q;
  assign fb_mask_o    = fb_mask_q;
  assign fb_addr_o    = fb_addr_q;
  assign fb_data_o    = fb_data_q;
  assign req_ack_0_o  = ack0_q;
  assign req_ack_1_o  = ack1_q;
  assign req_data_0_o = rdata0_q;
  assign req_data_1_o = rdata1_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter. The bench plays both requesters and the
// framebuffer; inputs change and outputs are sampled on the falling edge.
// Built with VRAM_ARB_WATCHDOG_EN it exercises the timeout path with
// TIMEOUT_CYCLES = 8, otherwise it checks that BUSY waits indefinitely.
// ----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int ADDR_W         = 24;
  localparam int DATA_W         = 16;
  localparam int MASK_W         = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic              clk = 1'b0;
  logic              resetN;
  logic              sel0, wr0, sel1, wr1;
  logic [MASK_W-1:0] mask0, mask1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              fbSel, fbWr;
  logic [MASK_W-1:0] fbMask;
  logic [ADDR_W-1:0] fbAddr;
  logic [DATA_W-1:0] fbWdata;
  logic              fbAck;
  logic [DATA_W-1:0] fbRdataIn;
  logic              grant, busy, errTimeout, errClr;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset_n_i(resetN),
    .req_sel_0_i(sel0), .req_wr_0_i(wr0), .req_mask_0_i(mask0),
    .req_addr_0_i(addr0), .req_data_0_i(wdata0),
    .req_ack_0_o(ack0), .req_data_0_o(rdata0),
    .req_sel_1_i(sel1), .req_wr_1_i(wr1), .req_mask_1_i(mask1),
    .req_addr_1_i(addr1), .req_data_1_i(wdata1),
    .req_ack_1_o(ack1), .req_data_1_o(rdata1),
    .fb_sel_o(fbSel), .fb_wr_o(fbWr), .fb_mask_o(fbMask),
    .fb_addr_o(fbAddr), .fb_data_o(fbWdata),
    .fb_ack_i(fbAck), .fb_data_i(fbRdataIn),
    .grant_o(grant), .busy_o(busy),
    .err_timeout_o(errTimeout), .err_clr_i(errClr)
  );

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one requester's request fields.
  task automatic applyStimulus(input int n, input logic sel, input logic wr,
                               input logic [MASK_W-1:0] mask,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    if (n == 0) begin
      sel0 = sel; wr0 = wr; mask0 = mask; addr0 = addr; wdata0 = data;
    end else begin
      sel1 = sel; wr1 = wr; mask1 = mask; addr1 = addr; wdata1 = data;
    end
  endtask

  // Act as the framebuffer for one access: wait (bounded) for fb_sel_o,
  // check the presented request, keep it open holdCycles more cycles, then
  // ack (or stay silent) and check the response. Returns on the ack cycle.
  task automatic serveOne(input string tag, input int expWait, input logic expGrant,
                          input logic [ADDR_W-1:0] expAddr,
                          input logic [DATA_W-1:0] expData,
                          input logic [MASK_W-1:0] expMask, input logic expWr,
                          input int holdCycles, input logic doAck,
                          input logic [DATA_W-1:0] fbRdata,
                          input logic [DATA_W-1:0] expRdata);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fbSel !== 1'b1 && n < 30);
    checkOutput({tag, "_wait"}, n, expWait);
    if (fbSel !== 1'b1) return;
    checkOutput({tag, "_grant"}, grant, expGrant);
    checkOutput({tag, "_addr"}, fbAddr, expAddr);
    checkOutput({tag, "_wdata"}, fbWdata, expData);
    checkOutput({tag, "_mask"}, fbMask, expMask);
    checkOutput({tag, "_wr"}, fbWr, expWr);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold"}, fbSel, 1'b1);
    end
    if (doAck) begin
      fbAck = 1'b1;
      fbRdataIn = fbRdata;
    end
    @(negedge clk);
    fbAck = 1'b0;
    checkOutput({tag, "_seldrop"}, fbSel, 1'b0);
    checkOutput({tag, "_ack"}, expGrant ? ack1 : ack0, 1'b1);
    checkOutput({tag, "_otherack"}, expGrant ? ack0 : ack1, 1'b0);
    checkOutput({tag, "_rdata"}, expGrant ? rdata1 : rdata0, expRdata);
  endtask

  initial begin
    resetN = 1'b0; fbAck = 1'b0; fbRdataIn = '0; errClr = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rst_fbsel", fbSel, 1'b0);
    checkOutput("rst_fbwr", fbWr, 1'b0);
    checkOutput("rst_fbaddr", fbAddr, 24'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grant, 1'b1);
    checkOutput("rst_ack0", ack0, 1'b0);
    checkOutput("rst_ack1", ack1, 1'b0);
    checkOutput("rst_rdata0", rdata0, 16'h0);
    checkOutput("rst_err", errTimeout, 1'b0);
    resetN = 1'b1;
    @(negedge clk);

    // Single read from requester 0; ack in the 4th fb_sel cycle.
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000123, 16'h0);
    serveOne("rd0", 1, 1'b0, 24'h000123, 16'h0, 4'hF, 1'b0, 3, 1'b1, 16'hABCD, 16'hABCD);
    checkOutput("rd0_rdata1", rdata1, 16'h0);
    applyStimulus(0, 1'b0, 1'b0, 4'hF, 24'h000123, 16'h0);
    @(negedge clk);
    checkOutput("rd0_ackpulse", ack0, 1'b0);
    checkOutput("rd0_idle", busy, 1'b0);
    checkOutput("rd0_holddata", rdata0, 16'hABCD);

    // Fresh reset, then a tie: requester 0 first, requester 1 two cycles later.
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000010, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 4'hF, 24'h000020, 16'h0);
    serveOne("tie0", 1, 1'b0, 24'h000010, 16'h0, 4'hF, 1'b0, 0, 1'b1, 16'h1111, 16'h1111);
    applyStimulus(0, 1'b0, 1'b0, 4'hF, 24'h000010, 16'h0);
    serveOne("tie1", 2, 1'b1, 24'h000020, 16'h0, 4'hF, 1'b0, 0, 1'b1, 16'h2222, 16'h2222);
    checkOutput("tie1_rdata0", rdata0, 16'h1111);

    // Next tie goes to requester 0; requester 1 then streams writes.
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000010, 16'h0);
    applyStimulus(1, 1'b1, 1'b1, 4'h3, 24'h000030, 16'hBEEF);
    serveOne("tie2", 2, 1'b0, 24'h000010, 16'h0, 4'hF, 1'b0, 0, 1'b1, 16'h3333, 16'h3333);
    serveOne("str1a", 2, 1'b1, 24'h000030, 16'hBEEF, 4'h3, 1'b1, 1, 1'b1, 16'h0042, 16'h0042);
    applyStimulus(1, 1'b1, 1'b1, 4'hC, 24'h000031, 16'hCAFE);
    serveOne("str0a", 2, 1'b0, 24'h000010, 16'h0, 4'hF, 1'b0, 1, 1'b1, 16'h4444, 16'h4444);
    serveOne("str1b", 2, 1'b1, 24'h000031, 16'hCAFE, 4'hC, 1'b1, 1, 1'b1, 16'h0055, 16'h0055);
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 24'h0, 16'h0);
    serveOne("str0b", 2, 1'b0, 24'h000010, 16'h0, 4'hF, 1'b0, 1, 1'b1, 16'h6666, 16'h6666);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 24'h0, 16'h0);
    repeat (2) @(negedge clk);

    // Reset asserted mid-access drops fb_sel_o at once and produces no ack.
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000055, 16'h0);
    @(negedge clk);
    checkOutput("rstbusy_open", fbSel, 1'b1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("rstbusy_fbsel", fbSel, 1'b0);
    checkOutput("rstbusy_busy", busy, 1'b0);
    checkOutput("rstbusy_grant", grant, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 24'h0, 16'h0);
    @(negedge clk);
    resetN = 1'b1;
    checkOutput("rstbusy_noack", ack0, 1'b0);
    checkOutput("rstbusy_rdata0", rdata0, 16'h0);
    @(negedge clk);
    checkOutput("rstbusy_noack2", ack0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 4'h5, 24'h000ABC, 16'h7777);
    serveOne("postrst", 1, 1'b1, 24'h000ABC, 16'h7777, 4'h5, 1'b1, 2, 1'b1, 16'h0009, 16'h0009);
    applyStimulus(1, 1'b0, 1'b0, 4'h0, 24'h0, 16'h0);
    repeat (2) @(negedge clk);

    // Stray fb_ack_i while idle changes nothing.
    fbAck = 1'b1;
    fbRdataIn = 16'h1234;
    @(negedge clk);
    fbAck = 1'b0;
    checkOutput("stray_fbsel", fbSel, 1'b0);
    checkOutput("stray_ack0", ack0, 1'b0);
    checkOutput("stray_ack1", ack1, 1'b0);
    checkOutput("stray_busy", busy, 1'b0);
    checkOutput("stray_rdata1", rdata1, 16'h0009);
    checkOutput("stray_grant", grant, 1'b1);
    @(negedge clk);
    checkOutput("stray_ack1_late", ack1, 1'b0);

`ifdef VRAM_ARB_WATCHDOG_EN
    // No ack: timeout in the 8th cycle; clear held high the whole time loses.
    errClr = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000077, 16'h0);
    serveOne("wdog", 1, 1'b0, 24'h000077, 16'h0, 4'hF, 1'b0, 7, 1'b0, 16'h0, 16'hFFFF);
    checkOutput("wdog_errset", errTimeout, 1'b1);
    errClr = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 24'h0, 16'h0);
    @(negedge clk);
    checkOutput("wdog_sticky", errTimeout, 1'b1);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    checkOutput("wdog_clr", errTimeout, 1'b0);
    // Ack arriving exactly in the timeout cycle wins.
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000078, 16'h0);
    serveOne("wdogack", 1, 1'b0, 24'h000078, 16'h0, 4'hF, 1'b0, 7, 1'b1, 16'h4321, 16'h4321);
    checkOutput("wdogack_noerr", errTimeout, 1'b0);
`else
    // Without the watchdog a slow framebuffer is simply waited for.
    errClr = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 4'hF, 24'h000077, 16'h0);
    serveOne("nowdog", 1, 1'b0, 24'h000077, 16'h0, 4'hF, 1'b0, 20, 1'b1, 16'h0BAD, 16'h0BAD);
    checkOutput("nowdog_noerr", errTimeout, 1'b0);
    errClr = 1'b0;
`endif
    applyStimulus(0, 1'b0, 1'b0, 4'h0, 24'h0, 16'h0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
